// File: rtl/id_stage.sv
// MIPS decode stage: regFile read addressing, decode, WB bypass, load-use bubble, ID/EX register.
// Define ID_BYPASS_EN for WB bypass muxes; otherwise a WB hit stalls one cycle.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_ready,
  output logic [REG_AW-1:0] rpa_num,
  output logic [REG_AW-1:0] rpb_num,
  input  logic [DATA_W-1:0] rpa_out,
  input  logic [DATA_W-1:0] rpb_out,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_num,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_opa,
  output logic [DATA_W-1:0] id_opb,
  output logic [DATA_W-1:0] id_imm,
  output logic [REG_AW-1:0] id_rd,
  output logic [2:0]        id_alu_op,
  output logic              id_reg_wr,
  output logic              id_mem_rd,
  output logic              id_mem_wr,
  output logic              id_use_imm
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd_r;

  assign op    = if_instr[31:26];
  assign funct = if_instr[5:0];
  assign rs    = if_instr[25:21];
  assign rt    = if_instr[20:16];
  assign rd_r  = if_instr[15:11];

  assign rpa_num = rs;
  assign rpb_num = rt;

  logic              op_r;
  logic              op_addi;
  logic              op_lw;
  logic              op_sw;

  assign op_r    = (op == 6'h00);
  assign op_addi = (op == 6'h08);
  assign op_lw   = (op == 6'h23);
  assign op_sw   = (op == 6'h2B);

  logic [2:0]        d_alu;
  logic [REG_AW-1:0] d_rd;
  logic              d_wr;
  logic              d_mrd;
  logic              d_mwr;
  logic              d_imm;
  logic              reads_rt;
  logic [DATA_W-1:0] imm;

  assign imm = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  always_comb begin
    d_alu    = ALU_ADD;
    d_rd     = '0;
    d_wr     = 1'b0;
    d_mrd    = 1'b0;
    d_mwr    = 1'b0;
    d_imm    = 1'b0;
    reads_rt = 1'b0;
    unique case (1'b1)
      op_r: begin
        reads_rt = 1'b1;
        d_rd     = rd_r;
        d_wr     = 1'b1;
        case (funct)
          6'h20:   d_alu = ALU_ADD;
          6'h22:   d_alu = ALU_SUB;
          6'h24:   d_alu = ALU_AND;
          6'h25:   d_alu = ALU_OR;
          6'h2A:   d_alu = ALU_SLT;
          default: begin
            d_rd = '0;
            d_wr = 1'b0;
          end
        endcase
      end
      op_addi: begin
        d_rd  = rt;
        d_wr  = 1'b1;
        d_imm = 1'b1;
      end
      op_lw: begin
        d_rd  = rt;
        d_wr  = 1'b1;
        d_mrd = 1'b1;
        d_imm = 1'b1;
      end
      op_sw: begin
        reads_rt = 1'b1;
        d_mwr    = 1'b1;
        d_imm    = 1'b1;
      end
      default: ;
    endcase
    if (d_rd == '0) d_wr = 1'b0;
  end

  logic              hit_a;
  logic              hit_b;
  logic              wb_hz;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  assign hit_a = wb_wr_en && (wb_num != '0) && (wb_num == rs);
  assign hit_b = wb_wr_en && (wb_num != '0) && (wb_num == rt);

`ifdef ID_BYPASS_EN
  assign wb_hz = 1'b0;
  assign opa   = (rs == '0) ? '0 : hit_a ? wb_data : rpa_out;
  assign opb   = (rt == '0) ? '0 : hit_b ? wb_data : rpb_out;
`else
  logic unused_wb;
  assign unused_wb = ^wb_data;
  assign wb_hz = hit_a || hit_b;
  assign opa   = (rs == '0) ? '0 : rpa_out;
  assign opb   = (rt == '0) ? '0 : rpb_out;
`endif

  logic ld_hz;
  logic stall;

  assign ld_hz = id_valid && id_mem_rd && (id_rd != '0) &&
                 ((id_rd == rs) || ((id_rd == rt) && reads_rt));
  assign stall = ld_hz || wb_hz;

  assign if_ready = flush || (ex_ready && !stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_opa     <= '0;
      id_opb     <= '0;
      id_imm     <= '0;
      id_rd      <= '0;
      id_alu_op  <= ALU_ADD;
      id_reg_wr  <= 1'b0;
      id_mem_rd  <= 1'b0;
      id_mem_wr  <= 1'b0;
      id_use_imm <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (ex_ready) begin
      if (stall) begin
        id_valid <= 1'b0;
      end else begin
        id_valid   <= if_valid;
        id_pc      <= if_pc;
        id_opa     <= opa;
        id_opb     <= opb;
        id_imm     <= imm;
        id_rd      <= d_rd;
        id_alu_op  <= d_alu;
        id_reg_wr  <= d_wr;
        id_mem_rd  <= d_mrd;
        id_mem_wr  <= d_mwr;
        id_use_imm <= d_imm;
      end
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- MIPS decode stage: sits between fetch and execute, directly upstream of the register file read ports.
- Drives the regFile read addresses (rpa_num/rpb_num) and consumes its combinational read data (rpa_out/rpb_out).
- Decodes the instruction and bypasses the writeback bus into the operands.
- Detects load-use hazards and registers everything into the ID/EX pipeline register with a valid/ready handshake.

Parameters:
DATA_W, 32, datapath and instruction width
REG_AW, 5, register address width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_instr  in  32  instruction word
if_pc  in  32  PC of if_instr
if_ready  out  1  ID accepts if_instr this cycle
rpa_num  out  5  regFile read port A address = if_instr[25:21] (rs)
rpb_num  out  5  regFile read port B address = if_instr[20:16] (rt)
rpa_out  in  32  regFile port A data, combinational
rpb_out  in  32  regFile port B data, combinational
wb_wr_en  in  1  writeback enable (same bus as regFile wr_en)
wb_num  in  5  writeback register
wb_data  in  32  writeback data
ex_ready  in  1  execute accepts ID/EX contents
flush  in  1  discard ID contents (branch redirect)
id_valid  out  1  ID/EX register holds a live instruction
id_pc  out  32  registered PC
id_opa  out  32  rs operand
id_opb  out  32  rt operand
id_imm  out  32  sign-extended instr[15:0]
id_rd  out  5  destination register
id_alu_op  out  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT
id_reg_wr  out  1  instruction writes a register
id_mem_rd  out  1  load
id_mem_wr  out  1  store
id_use_imm  out  1  ALU B input is id_imm

Behaviour:
- Reset: all id_* outputs 0, asynchronously. if_ready is combinational and need not be reset.
- Decode:
  - Opcode 0x00 decodes R-type: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. rd = instr[15:11].
  - 0x08 addi: ADD, use_imm, rd = rt.
  - 0x23 lw: ADD, use_imm, mem_rd, rd = rt.
  - 0x2B sw: ADD, use_imm, mem_wr, reg_wr = 0.
  - Any other opcode or funct is a NOP: reg_wr, mem_rd and mem_wr all 0, alu_op ADD, still valid.
  - rd == 0 forces id_reg_wr = 0.
- Operands: opa = rpa_out and opb = rpb_out, subject to the bypass below. Reading r0 always yields 0, independent of the regFile.
- WB bypass: if wb_wr_en && wb_num != 0 && wb_num == rs, then opa = wb_data. The same rule applies to rt and opb. This covers the same-edge write/read case.
- Load-use hazard:
  - hz = id_valid && id_mem_rd && id_rd != 0 && (id_rd == rs || (id_rd == rt && the current instruction reads rt)).
  - Instructions that read rt: R-type and sw.
- ID/EX update, by priority:
  1. rst
  2. flush: id_valid <= 0, if_ready = 1, instruction dropped
  3. !ex_ready: hold all ID/EX outputs, if_ready = 0
  4. hz: bubble (id_valid <= 0, other fields don't-care), if_ready = 0
  5. otherwise: capture decode and id_valid <= if_valid, if_ready = 1
- A hazard stalls exactly one cycle: after the bubble the load has left ID/EX.
- Reset mid-stall: outputs clear immediately; if_ready = 1 after release when ex_ready = 1.
- Latency: 1 cycle from accepted if_instr to id_valid.

Optional Feature:
ID_BYPASS_EN
- Defined: WB bypass as above.
- Undefined: no bypass muxes. Any WB-bypass match is instead treated like hz: one-cycle bubble, if_ready = 0. Operands are read from the regFile in the following cycle.

Test Plan:
- Reset: rst = 1 mid-run with id_valid = 1 -> every id_* output reads 0 in the same cycle, before any clock edge.
- Decode add: if_instr 0x00221820 (add r3,r1,r2), r1 = 6, r2 = 9, ex_ready = 1 -> next cycle id_valid = 1, opa = 6, opb = 9, rd = 3, alu_op = 0, reg_wr = 1, use_imm = 0.
- Bypass: regFile r1 = 6; wb_wr_en = 1, wb_num = 1, wb_data = 42 while ID decodes add r3,r1,r2 -> opa = 42.
  - Without ID_BYPASS_EN: one bubble, then opa reads r1 from the regFile = 42.
- Load-use: lw r4,8(r0) (0x8C040008) followed by addi r5,r4,1 (0x20850001) -> one bubble, if_ready = 0 for 1 cycle; addi issues the next cycle with imm = 1, rd = 5.
- Backpressure/flush: ex_ready = 0 for 3 cycles -> id_* held, if_ready = 0. flush = 1 with if_valid = 1 -> id_valid = 0 next cycle, if_ready = 1.
- Edge decode: if_instr 0x20000005 (addi r0,r0,5) -> reg_wr = 0, imm = 5. if_instr 0xFC000000 -> NOP with id_valid = 1, imm 0xFFFF8000 from 0x20008000 (sign-extension check).
